// File: rtl/reg_file.sv
// Parametrised register file: one synchronous write port, two combinational read ports.
// Supports synchronous clear, an optional hardwired-zero register 0 and optional
// same-cycle write-to-read forwarding.
module reg_file #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter bit          ZERO_R0 = 1'b1,
  parameter bit          BYPASS  = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b
);

  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DepthLim = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_accept;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return {1'b0, addr} < DepthLim;
  endfunction

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return ZERO_R0 && (addr == '0);
  endfunction

  // A write lands only if enabled, not overridden by clear, in range and not to a hardwired R0.
  always_comb begin
    wr_accept = 1'b0;
    if (reset && we && !clr && in_range(waddr) && !is_zero_reg(waddr)) begin
      wr_accept = 1'b1;
    end
  end

  // Storage: async reset clears everything; clear beats a simultaneous write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (clr) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_accept) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read port A: range and R0 overrides first, then optional forwarding, then storage.
  always_comb begin
    rdata_a = '0;
    if (!reset || !in_range(raddr_a) || is_zero_reg(raddr_a)) begin
      rdata_a = '0;
    end else if (BYPASS && wr_accept && (waddr == raddr_a)) begin
      rdata_a = wdata;
    end else begin
      rdata_a = mem_q[raddr_a];
    end
  end

  // Read port B: identical to port A, fully independent.
  always_comb begin
    rdata_b = '0;
    if (!reset || !in_range(raddr_b) || is_zero_reg(raddr_b)) begin
      rdata_b = '0;
    end else if (BYPASS && wr_accept && (waddr == raddr_b)) begin
      rdata_b = wdata;
    end else begin
      rdata_b = mem_q[raddr_b];
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file. Two instances share all inputs:
//   u_z : DEPTH=32, ZERO_R0=1, BYPASS=0
//   u_y : DEPTH=20, ZERO_R0=0, BYPASS=1
// Expected read data is computed from a behavioural model, queued, then popped and compared.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        clr;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr_a;
  logic [4:0]  raddr_b;
  logic [31:0] za, zb, ya, yb;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mdl_z [32];
  logic [31:0] mdl_y [32];
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  reg_file #(
    .WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_R0(1'b1), .BYPASS(1'b0)
  ) u_z (
    .clk(clk), .reset(reset), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(za), .raddr_b(raddr_b), .rdata_b(zb)
  );

  reg_file #(
    .WIDTH(32), .DEPTH(20), .ADDR_W(5), .ZERO_R0(1'b0), .BYPASS(1'b1)
  ) u_y (
    .clk(clk), .reset(reset), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(ya), .raddr_b(raddr_b), .rdata_b(yb)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit accepts(input bit sel_y, input logic [4:0] a);
    int depth = sel_y ? 20 : 32;
    bit zr    = sel_y ? 1'b0 : 1'b1;
    if (int'(a) >= depth) return 1'b0;
    if (zr && a == 5'd0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_rd(input bit sel_y, input logic [4:0] a);
    int depth = sel_y ? 20 : 32;
    bit zr    = sel_y ? 1'b0 : 1'b1;
    bit byp   = sel_y;
    if (reset !== 1'b1) return 32'h0;
    if (int'(a) >= depth) return 32'h0;
    if (zr && a == 5'd0) return 32'h0;
    if (byp && we && !clr && waddr == a && accepts(sel_y, waddr)) return wdata;
    return sel_y ? mdl_y[a] : mdl_z[a];
  endfunction

  task automatic clear_models();
    for (int i = 0; i < 32; i++) begin
      mdl_z[i] = 32'h0;
      mdl_y[i] = 32'h0;
    end
  endtask

  // Advance one edge, updating the model with the inputs seen at that edge.
  task automatic tick();
    @(posedge clk);
    if (reset !== 1'b1) begin
      clear_models();
    end else if (clr) begin
      clear_models();
    end else if (we) begin
      if (accepts(1'b0, waddr)) mdl_z[waddr] = wdata;
      if (accepts(1'b1, waddr)) mdl_y[waddr] = wdata;
    end
    #1;
  endtask

  task automatic sb_push();
    exp_q.push_back(exp_rd(1'b0, raddr_a));
    exp_q.push_back(exp_rd(1'b0, raddr_b));
    exp_q.push_back(exp_rd(1'b1, raddr_a));
    exp_q.push_back(exp_rd(1'b1, raddr_b));
  endtask

  task automatic sb_check(input string tag);
    #1;
    check_eq({tag, "/z_a"}, za, exp_q.pop_front());
    check_eq({tag, "/z_b"}, zb, exp_q.pop_front());
    check_eq({tag, "/y_a"}, ya, exp_q.pop_front());
    check_eq({tag, "/y_b"}, yb, exp_q.pop_front());
  endtask

  task automatic read_check(input string tag, input logic [4:0] a, input logic [4:0] b);
    raddr_a = a;
    raddr_b = b;
    sb_push();
    sb_check(tag);
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    we    = 1'b1;
    waddr = a;
    wdata = d;
    tick();
    we    = 1'b0;
  endtask

  initial begin
    clear_models();
    // Reset held low with a pending write: reads stay 0.
    reset = 1'b0; clr = 1'b0; we = 1'b1; waddr = 5'd3; wdata = 32'hAFAFAFAF;
    raddr_a = 5'd3; raddr_b = 5'd3;
    #1;
    read_check("rst_hold0", 5'd3, 5'd3);
    #8;
    read_check("rst_hold1", 5'd3, 5'd3);
    #8;
    read_check("rst_hold2", 5'd3, 5'd3);
    #4;
    reset = 1'b1;
    tick();
    we = 1'b0;
    read_check("rst_release_wr", 5'd3, 5'd3);

    // Both ports, distinct and same address.
    write_reg(5'd5, 32'h12345678);
    write_reg(5'd9, 32'hDEADBEEF);
    read_check("rd_5_9", 5'd5, 5'd9);
    read_check("rd_9_9", 5'd9, 5'd9);

    // Register 0: hardwired on u_z, writable on u_y.
    write_reg(5'd0, 32'hFFFFFFFF);
    read_check("r0", 5'd0, 5'd0);

    // Forwarding: u_y sees new data before the edge, u_z only after.
    write_reg(5'd7, 32'h00000001);
    we = 1'b1; waddr = 5'd7; wdata = 32'h00000002;
    read_check("byp_before", 5'd7, 5'd7);
    tick();
    we = 1'b0;
    read_check("byp_after", 5'd7, 5'd7);

    // Clear beats a simultaneous write.
    write_reg(5'd1, 32'h11111111);
    write_reg(5'd2, 32'h22222222);
    write_reg(5'd3, 32'h33333333);
    write_reg(5'd4, 32'h44444444);
    read_check("pre_clr", 5'd2, 5'd4);
    clr = 1'b1; we = 1'b1; waddr = 5'd2; wdata = 32'hA5A5A5A5;
    tick();
    clr = 1'b0; we = 1'b0;
    read_check("clr_1_2", 5'd1, 5'd2);
    read_check("clr_3_4", 5'd3, 5'd4);
    read_check("clr_7_9", 5'd7, 5'd9);

    // Out-of-range write on u_y (DEPTH=20), in range on u_z.
    write_reg(5'd5, 32'h0BADF00D);
    write_reg(5'd9, 32'hC0FFEE00);
    write_reg(5'd25, 32'h5A5A5A5A);
    for (int i = 0; i < 32; i += 2) begin
      read_check($sformatf("oor_scan%0d", i), 5'(i), 5'(i + 1));
    end
    // Discarded write is never forwarded.
    we = 1'b1; waddr = 5'd25; wdata = 32'h77777777;
    read_check("oor_nobyp", 5'd25, 5'd5);
    tick();
    we = 1'b0;

    // Async reset between edges drops reads immediately.
    write_reg(5'd3, 32'hCAFEBABE);
    read_check("pre_async", 5'd3, 5'd9);
    #2;
    reset = 1'b0;
    clear_models();
    read_check("async_rst", 5'd3, 5'd9);
    #3;
    reset = 1'b1;
    tick();
    read_check("post_async", 5'd3, 5'd25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
